cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between the four ALU result producers (alu1..alu4) of the Tomasulo core.
- Each requester has a small result FIFO. One result per cycle is broadcast, chosen by round-robin, to the ROB, the reservation stations and the regfile.
- Back-pressure goes to each reservation station through req_ready, so a station holds its issue while its result FIFO is full.
- A branch-mispredict flush discards all buffered results.

Parameters:
- NUM_REQ, 4, number of requesters (ALUs); 2..8.
- DEPTH, 2, result FIFO entries per requester; power of 2, >=1.
- TAG_W, 3, ROB tag width (8-entry ROB).
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush, synchronous.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_ready  out  NUM_REQ  per-requester FIFO can accept.
- req_tag  in  NUM_REQ*TAG_W  ROB tags; requester i at bits [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  results; requester i at bits [i*DATA_W +: DATA_W].
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast ROB tag (registered).
- cdb_data  out  DATA_W  broadcast value (registered).
- cdb_src  out  $clog2(NUM_REQ)  index of the winning requester (registered).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst, sampled at the posedge.
- Reset values:
  - cdb_valid/cdb_tag/cdb_data/cdb_src = 0.
  - All FIFOs empty; rr_ptr = 0.
  - req_ready = 0 while rst is high; all 1 on the first cycle after rst deasserts.
- Push:
  - req_ready[i] = !rst && (count[i] != DEPTH), derived from occupancy only.
  - A full FIFO that is popping this cycle still shows ready=0; there is no same-cycle pass-through.
  - Push on req_valid[i] && req_ready[i] at the posedge; req_valid with ready=0 is ignored, and the requester must hold it.
- Arbitration (combinational, each cycle):
  - Candidates = FIFOs non-empty at the start of the cycle.
  - Winner = first candidate scanning from rr_ptr upward, mod NUM_REQ.
  - If a winner exists: pop its head. At the posedge load cdb_valid=1, cdb_tag/cdb_data = head, cdb_src = winner. Then rr_ptr <= (winner+1) mod NUM_REQ.
  - If no candidate: cdb_valid <= 0; cdb_tag/cdb_data/cdb_src hold their previous values; rr_ptr unchanged.
- Latency: a result pushed at edge k is eligible in cycle k..k+1. If it wins, it is visible on the CDB in cycle k+1..k+2, one cycle after acceptance. There is no input-to-CDB bypass.
- FIFO order: strict FIFO per requester; no ordering between requesters.
- Push and pop on the same FIFO in one cycle: allowed when not full; count unchanged.
- FIFO pointers wrap mod DEPTH; count is $clog2(DEPTH)+1 bits.
- Fairness: any non-empty FIFO is granted within NUM_REQ cycles.
- Flush (priority below rst, above everything else):
  - At the posedge: all FIFOs emptied, cdb_valid <= 0, rr_ptr <= 0.
  - Pushes presented in the flush cycle are dropped.
  - req_ready = all 1 in the following cycle.
- Reset or flush mid-stream: a pending broadcast is lost; no partial state remains.

Optional Feature:
- Macro CDB_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt, NUM_REQ*32 bits.
  - Counter i increments each cycle that req_valid[i] && !req_ready[i]; it saturates at 32'hFFFF_FFFF.
  - Counters clear on rst only; flush does not clear them.
- Undefined: the port and its counters are absent; all other behaviour is identical.

Test Plan:
- Reset -> during rst all outputs 0 and req_ready=0000; first cycle after rst, req_ready=1111 and cdb_valid=0.
- Single push from requester 1, tag 5, data 32'hDEADBEEF at edge k -> cycle after edge k+1: cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_src=1; cdb_valid=0 the following cycle.
- All 4 push in one cycle with rr_ptr=0, tags 0..3 -> cdb_src sequence 0,1,2,3 on 4 consecutive cycles with matching tags, then cdb_valid=0.
- All 4 push every cycle whenever ready, DEPTH=2 -> each FIFO fills; req_ready[i] toggles; each src granted exactly once per 4 cycles; no result lost or duplicated (scoreboard).
- Requester 0 pushes continuously, requester 3 pushes once -> requester 3 broadcast within 4 cycles of becoming eligible.
- 3 FIFOs holding entries, flush=1 with a concurrent push on requester 2 -> next cycle cdb_valid=0, req_ready=1111; no stale or dropped-push tag ever appears on the CDB afterward.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-ALU result FIFOs with round-robin grant onto the CDB.
// Optional CDB_ARB_PERF_EN adds per-requester back-pressure stall counters.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]      perf_stall_cnt
`endif
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0]  tag_mem  [NUM_REQ][DEPTH];
    logic [DATA_W-1:0] data_mem [NUM_REQ][DEPTH];

    logic [PW-1:0] wr_q  [NUM_REQ];
    logic [PW-1:0] wr_d  [NUM_REQ];
    logic [PW-1:0] rd_q  [NUM_REQ];
    logic [PW-1:0] rd_d  [NUM_REQ];
    logic [CW-1:0] cnt_q [NUM_REQ];
    logic [CW-1:0] cnt_d [NUM_REQ];

    logic [SW-1:0]     rr_q, rr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SW-1:0]     cdb_src_q, cdb_src_d;

    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               grant_vld;
    logic [SW-1:0]      grant_idx;
    int                 idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready reflects occupancy only, so a full FIFO never passes through
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (cnt_q[i] != CW'(DEPTH));
        end
    end

    // Round-robin scan from rr_q; lowest offset wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (cnt_q[idx] != '0) begin
                grant_vld = 1'b1;
                grant_idx = SW'(idx);
            end
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i]  = req_valid[i] && req_ready[i] && !flush;
            pop[i]   = grant_vld && (grant_idx == SW'(i));
            wr_d[i]  = push[i] ? ptr_inc(wr_q[i]) : wr_q[i];
            rd_d[i]  = pop[i] ? ptr_inc(rd_q[i]) : rd_q[i];
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Broadcast register next state; payload holds when idle
    always_comb begin
        cdb_valid_d = grant_vld;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_d        = rr_q;
        if (grant_vld) begin
            cdb_tag_d  = tag_mem[grant_idx][rd_q[grant_idx]];
            cdb_data_d = data_mem[grant_idx][rd_q[grant_idx]];
            cdb_src_d  = grant_idx;
            rr_d       = (grant_idx == SW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Result storage; writes are gated by push
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_q[i]]  <= req_tag[i*TAG_W +: TAG_W];
                data_mem[i][wr_q[i]] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO state; reset and flush both empty every FIFO
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst || flush) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end else begin
                wr_q[i]  <= wr_d[i];
                rd_q[i]  <= rd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Arbiter pointer and broadcast registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else if (flush) begin
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] stall_q [NUM_REQ];

    // Saturating count of cycles a requester is held off; flush keeps them
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                stall_q[i] <= '0;
            end else if (req_valid[i] && !req_ready[i] &&
                         (stall_q[i] != 32'hFFFF_FFFF)) begin
                stall_q[i] <= stall_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_stall_cnt[g*32 +: 32] = stall_q[g];
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a queue-based model.
// Model tracks per-requester queues, grant pointer and expected CDB state.
module tb_cdb_arbiter;

    localparam int NR = 4;
    localparam int DP = 2;

    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*3-1:0]  req_tag;
    logic [NR*32-1:0] req_data;
    logic          cdb_valid;
    logic [2:0]    cdb_tag;
    logic [31:0]   cdb_data;
    logic [1:0]    cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [NR*32-1:0] perf_stall_cnt;
    logic [31:0]      m_stall [NR];
`endif

    int total = 0;
    int bad   = 0;

    ent_t        q [NR][$];
    int          rr;
    logic        m_valid;
    logic [2:0]  m_tag;
    logic [31:0] m_data;
    logic [1:0]  m_src;

    cdb_arbiter #(.NUM_REQ(NR), .DEPTH(DP), .TAG_W(3), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] m_ready();
        logic [NR-1:0] r;
        for (int i = 0; i < NR; i++) r[i] = !rst && (q[i].size() != DP);
        return r;
    endfunction

    task automatic model_edge();
        int   w;
        ent_t e;
        logic [NR-1:0] acc;
        w = -1;
`ifdef CDB_ARB_PERF_EN
        for (int i = 0; i < NR; i++) begin
            if (rst) m_stall[i] = '0;
            else if (req_valid[i] && q[i].size() == DP &&
                     m_stall[i] != 32'hFFFF_FFFF) m_stall[i]++;
        end
`endif
        if (rst) begin
            for (int i = 0; i < NR; i++) q[i].delete();
            m_valid = 0; m_tag = 0; m_data = 0; m_src = 0; rr = 0;
        end else if (flush) begin
            for (int i = 0; i < NR; i++) q[i].delete();
            m_valid = 0; rr = 0;
        end else begin
            for (int i = 0; i < NR; i++)
                acc[i] = req_valid[i] && (q[i].size() < DP);
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (rr + k) % NR;
                if (w < 0 && q[j].size() > 0) w = j;
            end
            if (w >= 0) begin
                e = q[w].pop_front();
                m_valid = 1; m_tag = e.tag; m_data = e.data;
                m_src = 2'(w); rr = (w + 1) % NR;
            end else begin
                m_valid = 0;
            end
            for (int i = 0; i < NR; i++)
                if (acc[i]) q[i].push_back({req_tag[i*3 +: 3], req_data[i*32 +: 32]});
        end
    endtask

    task automatic compare_all();
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_tag",   64'(cdb_tag),   64'(m_tag));
        check("cdb_data",  64'(cdb_data),  64'(m_data));
        check("cdb_src",   64'(cdb_src),   64'(m_src));
        check("req_ready", 64'(req_ready), 64'(m_ready()));
`ifdef CDB_ARB_PERF_EN
        for (int i = 0; i < NR; i++)
            check("perf_stall", 64'(perf_stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] t,
                           input logic [31:0] d);
        req_valid[i]      = v;
        req_tag[i*3 +: 3] = t;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic drv(input int i, input logic v);
        if (!(req_valid[i] && q[i].size() == DP))
            set_req(i, v, 3'($urandom), $urandom);
    endtask

    int seen;

    initial begin
        rst = 1; flush = 0; req_valid = '0; req_tag = '0; req_data = '0;
        step();
        step();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_valid", 64'(cdb_valid), 64'h0);
        rst = 0;
        #1 check("post_rst_ready", 64'(req_ready), 64'hF);
        step();
        check("post_rst_cdbv", 64'(cdb_valid), 64'h0);

        set_req(1, 1, 3'd5, 32'hDEADBEEF);
        step();
        req_valid = '0;
        step();
        check("single_v",   64'(cdb_valid), 64'h1);
        check("single_tag", 64'(cdb_tag),   64'h5);
        check("single_dat", 64'(cdb_data),  64'hDEADBEEF);
        check("single_src", 64'(cdb_src),   64'h1);
        step();
        check("single_idle", 64'(cdb_valid), 64'h0);

        flush = 1; step(); flush = 0;
        for (int i = 0; i < NR; i++) set_req(i, 1, 3'(i), 32'h1000 + i);
        step();
        req_valid = '0;
        for (int k = 0; k < NR; k++) begin
            step();
            check("all4_v",   64'(cdb_valid), 64'h1);
            check("all4_src", 64'(cdb_src),   64'(k));
            check("all4_tag", 64'(cdb_tag),   64'(k));
        end
        step();
        check("all4_idle", 64'(cdb_valid), 64'h0);

        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NR; i++) drv(i, 1);
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 10; c++) step();

        flush = 1; step(); flush = 0;
        seen = 99;
        for (int c = 0; c < 12; c++) begin
            drv(0, 1);
            if (c == 3) set_req(3, 1, 3'd6, 32'hFA1F_0003);
            else if (c == 4) req_valid[3] = 0;
            step();
            if (c >= 4 && seen == 99 && cdb_valid && cdb_src == 2'd3)
                seen = c - 3;
        end
        check("fair_r3", 64'(seen <= NR), 64'h1);
        req_valid = '0;
        for (int c = 0; c < 6; c++) step();

        for (int c = 0; c < 2; c++) begin
            set_req(0, 1, 3'($urandom), $urandom);
            set_req(1, 1, 3'($urandom), $urandom);
            set_req(3, 1, 3'($urandom), $urandom);
            step();
        end
        req_valid = '0;
        flush = 1;
        set_req(2, 1, 3'd7, 32'hBAD0F00D);
        step();
        flush = 0; req_valid = '0;
        check("flush_v",     64'(cdb_valid), 64'h0);
        check("flush_ready", 64'(req_ready), 64'hF);
        for (int c = 0; c < 6; c++) begin
            step();
            check("flush_quiet", 64'(cdb_valid), 64'h0);
        end

        for (int c = 0; c < 3000; c++) begin
            int pv;
            pv = (c / 500) % 3 + 1;
            for (int i = 0; i < NR; i++) drv(i, $urandom_range(0, 3) < pv);
            flush = ($urandom_range(0, 63) == 0);
            rst   = (c == 1700);
            step();
            flush = 0;
            rst   = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
